// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream, payload-write and command handshake bundle for uart_cmd_ctrl.
// master: controller side (rx in, mem/cmd out); slave: environment side.
interface uart_cmd_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;
  logic              cmd_valid;
  logic [7:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              cmd_ready;

  modport master (
    input  rx_valid, rx_data, cmd_ready,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output cmd_valid, cmd_op, cmd_addr, cmd_len
  );

  modport slave (
    output rx_valid, rx_data, cmd_ready,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  cmd_valid, cmd_op, cmd_addr, cmd_len
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command-frame parser: A5,OP,ADDR,LEN,payload,CHK -> mem writes + cmd.
// Ports: clk, rst_n, bus (rx/mem/cmd), frame_err, err_code, busy.
module uart_cmd_ctrl #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 10_000,
  parameter int TIMEOUT_BITS = 20,
  parameter int ADDR_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_ctrl_if.master bus,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic            busy
);
  localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
  localparam int TMO_MAX = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int TW = $clog2(TMO_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OP    = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_ISSUE = 3'd6;

  localparam logic [7:0] SYNC = 8'hA5;

  logic [2:0]        state;
  logic [2:0]        state_d;
  logic [7:0]        op_q;
  logic [7:0]        len_q;
  logic [7:0]        idx;
  logic [7:0]        acc;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     tmo;
  logic              in_frame;
  logic              tmo_hit;
  logic              chk_ok;
  logic              accept;
  logic              last_data;

  assign in_frame = (state >= S_OP) && (state <= S_CHK);
  // Expire on the cycle the idle count would reach TMO_MAX.
  assign tmo_hit = in_frame && !bus.rx_valid
                && (tmo == TW'(TMO_MAX - 1));
  assign chk_ok = (bus.rx_data == acc);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign last_data = (idx == len_q - 8'd1);

  always_comb begin
    state_d = state;
    unique case (1'b1)
      state == S_IDLE:
        if (bus.rx_valid && bus.rx_data == SYNC)
          state_d = S_OP;
      state == S_OP:
        if (bus.rx_valid) state_d = S_ADDR;
      state == S_ADDR:
        if (bus.rx_valid) state_d = S_LEN;
      state == S_LEN:
        if (bus.rx_valid)
          state_d = (bus.rx_data != 8'd0) ? S_DATA : S_CHK;
      state == S_DATA:
        if (bus.rx_valid && last_data) state_d = S_CHK;
      state == S_CHK:
        if (bus.rx_valid)
          state_d = chk_ok ? S_ISSUE : S_IDLE;
      state == S_ISSUE:
        if (accept) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      op_q            <= '0;
      len_q           <= '0;
      addr_q          <= '0;
      idx             <= '0;
      acc             <= '0;
      tmo             <= '0;
      frame_err       <= 1'b0;
      err_code        <= 2'd0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_wr_addr <= '0;
      bus.mem_wr_data <= '0;
      bus.cmd_valid   <= 1'b0;
      bus.cmd_op      <= '0;
      bus.cmd_addr    <= '0;
      bus.cmd_len     <= '0;
    end else begin
      state         <= state_d;
      busy          <= (state_d != S_IDLE);
      bus.mem_wr_en <= 1'b0;
      frame_err     <= 1'b0;
      tmo <= (in_frame && !bus.rx_valid) ? tmo + TW'(1) : '0;
      if (bus.rx_valid) begin
        unique case (1'b1)
          state == S_IDLE: acc <= '0;
          state == S_OP: begin
            op_q <= bus.rx_data;
            acc  <= acc ^ bus.rx_data;
          end
          state == S_ADDR: begin
            addr_q <= ADDR_W'(bus.rx_data);
            acc    <= acc ^ bus.rx_data;
          end
          state == S_LEN: begin
            len_q <= bus.rx_data;
            idx   <= '0;
            acc   <= acc ^ bus.rx_data;
          end
          state == S_DATA: begin
            bus.mem_wr_en   <= 1'b1;
            bus.mem_wr_addr <= addr_q + ADDR_W'(idx);
            bus.mem_wr_data <= bus.rx_data;
            idx             <= idx + 8'd1;
            acc             <= acc ^ bus.rx_data;
          end
          state == S_CHK: begin
            if (chk_ok) begin
              bus.cmd_valid <= 1'b1;
              bus.cmd_op    <= op_q;
              bus.cmd_addr  <= addr_q;
              bus.cmd_len   <= len_q;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
            end
          end
          state == S_ISSUE: begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
          end
          default: ;
        endcase
      end
      if (accept) bus.cmd_valid <= 1'b0;
      if (tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'd2;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized frame bench for uart_cmd_ctrl with a frame-level reference model.
// Uses a faster clock-per-bit so the timeout case stays short.
module tb_uart_cmd_ctrl;
  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD = 10_000;
  localparam int TBITS = 20;
  localparam int AW = 8;
  localparam int TMO = TBITS * (CLK_FREQ / BAUD);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_cmd_ctrl_if #(.ADDR_W(AW)) bus ();

  uart_cmd_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .TIMEOUT_BITS(TBITS),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .frame_err(frame_err),
    .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] exp_wr[$];
  logic [31:0] got_wr[$];
  logic [31:0] exp_cmd[$];
  logic [31:0] got_cmd[$];
  logic [31:0] exp_err[$];
  logic [31:0] got_err[$];
  logic [7:0]  pl[$];
  int          err_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  logic        pv = 1'b0;
  logic [23:0] pf = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (bus.mem_wr_en)
        got_wr.push_back({16'd0, bus.mem_wr_addr, bus.mem_wr_data});
      if (bus.cmd_valid && pv)
        check("cmd_hold",
              {8'd0, bus.cmd_op, bus.cmd_addr, bus.cmd_len},
              {8'd0, pf});
      if (bus.cmd_valid && bus.cmd_ready)
        got_cmd.push_back({8'd0, bus.cmd_op, bus.cmd_addr, bus.cmd_len});
      if (frame_err) begin
        got_err.push_back({30'd0, err_code});
        err_cyc = cyc;
      end
      pv = bus.cmd_valid && !bus.cmd_ready;
      pf = {bus.cmd_op, bus.cmd_addr, bus.cmd_len};
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  // Reference model: payload byte i lands at (addr+i) mod 256; a good
  // checksum yields one command, a bad one yields error code 1.
  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] flip);
    logic [7:0] len;
    logic [7:0] chk;
    len = 8'(pl.size());
    chk = op ^ addr ^ len;
    foreach (pl[i]) chk ^= pl[i];
    foreach (pl[i])
      exp_wr.push_back({16'd0, 8'(int'(addr) + i), pl[i]});
    if (flip == 8'd0) exp_cmd.push_back({8'd0, op, addr, len});
    else exp_err.push_back(32'd1);
    send_byte(8'hA5); gap();
    send_byte(op);    gap();
    send_byte(addr);  gap();
    send_byte(len);   gap();
    foreach (pl[i]) begin
      send_byte(pl[i]);
      gap();
    end
    send_byte(chk ^ flip);
  endtask

  task automatic settle(input string t);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({t, ":wr_n"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check({t, ":wr"}, got_wr[i], exp_wr[i]);
    check({t, ":cmd_n"}, got_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
      check({t, ":cmd"}, got_cmd[i], exp_cmd[i]);
    check({t, ":err_n"}, got_err.size(), exp_err.size());
    for (int i = 0; i < exp_err.size() && i < got_err.size(); i++)
      check({t, ":err"}, got_err[i], exp_err[i]);
    check({t, ":busy"}, 32'(busy), 32'd0);
    check({t, ":cvld"}, 32'(bus.cmd_valid), 32'd0);
    exp_wr.delete();  got_wr.delete();
    exp_cmd.delete(); got_cmd.delete();
    exp_err.delete(); got_err.delete();
  endtask

  task automatic check_zero(input string t);
    check({t, ":wr_en"}, 32'(bus.mem_wr_en), 32'd0);
    check({t, ":cvld"}, 32'(bus.cmd_valid), 32'd0);
    check({t, ":cop"}, 32'(bus.cmd_op), 32'd0);
    check({t, ":ferr"}, 32'(frame_err), 32'd0);
    check({t, ":code"}, 32'(err_code), 32'd0);
    check({t, ":busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int c0;
    int lat;
    logic [7:0] j;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'd0;
    bus.cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    pl = '{8'h11, 8'h22};
    send_frame(8'h01, 8'h10, 8'h00);
    settle("good");
    check("good:code", 32'(err_code), 32'd0);

    send_frame(8'h01, 8'h10, 8'h01);
    settle("badchk");
    check("badchk:code", 32'(err_code), 32'd1);

    send_byte(8'h00);
    send_byte(8'hFF);
    pl = {};
    send_frame(8'h07, 8'h30, 8'h00);
    settle("empty");

    send_byte(8'hA5);
    check("tmo:busy", 32'(busy), 32'd1);
    send_byte(8'h01);
    c0 = cyc;
    for (int i = 0; i < TMO + 100 && got_err.size() == 0; i++)
      @(posedge clk);
    @(negedge clk);
    check("tmo:seen", got_err.size(), 32'd1);
    if (got_err.size() > 0) begin
      lat = err_cyc - c0;
      check("tmo:code", got_err[0], 32'd2);
      check("tmo:lat_ok", 32'(lat >= TMO - 1 && lat <= TMO + 1), 32'd1);
    end
    got_err.delete();
    settle("tmo");
    pl = '{8'h5A, 8'hA5, 8'h3C};
    send_frame(8'h09, 8'h40, 8'h00);
    settle("post_tmo");
    check("post_tmo:code", 32'(err_code), 32'd2);

    bus.cmd_ready = 1'b0;
    pl = '{8'hDE, 8'hAD};
    send_frame(8'h42, 8'h80, 8'h00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp:cvld", 32'(bus.cmd_valid), 32'd1);
    send_byte(8'h55);
    exp_err.push_back(32'd3);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("bp:cvld2", 32'(bus.cmd_valid), 32'd1);
    check("bp:op", 32'(bus.cmd_op), 32'h42);
    check("bp:addr", 32'(bus.cmd_addr), 32'h80);
    check("bp:len", 32'(bus.cmd_len), 32'd2);
    check("bp:none", got_cmd.size(), 32'd0);
    check("bp:code", 32'(err_code), 32'd3);
    @(posedge clk);
    #1;
    bus.cmd_ready = 1'b1;
    settle("bp");

    pl = '{8'hAA, 8'hBB};
    send_frame(8'h05, 8'hFF, 8'h00);
    settle("wrap");

    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'hAA);
    exp_wr.push_back({16'd0, 8'hFF, 8'hAA});
    @(negedge clk);
    #1;
    check("rst:wr_pre", 32'(bus.mem_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h00);
    settle("rst");

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 2)) begin
        do j = 8'($urandom_range(0, 255)); while (j == 8'hA5);
        send_byte(j);
      end
      pl = {};
      repeat ($urandom_range(0, 6)) pl.push_back(8'($urandom_range(0, 255)));
      send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255))
                                             : 8'd0);
      settle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
